// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add/sub issue/capture stage.
// Optional build macro: FP_ADDSUB_NAN_CANON_EN (NaN canonicalisation and NV flag).
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = 31;

    // Flag vector layout: {NV, OF, UF} with NV present only in the NaN build.
    localparam int FLAG_UF = 0;
    localparam int FLAG_OF = 1;

`ifdef FP_ADDSUB_NAN_CANON_EN
    localparam int FLAG_NV = 2;
    localparam int FLAG_N  = 3;

    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;
    localparam int FP_MAN_MSB = 22;

    localparam logic [FP_W-1:0] CANON_NAN = 32'h7FC0_0000;
`else
    localparam int FLAG_N  = 2;
`endif

    // Subtraction is addition with operand B's sign inverted.
    function automatic logic [FP_W-1:0] apply_sub(input logic [FP_W-1:0] b, input logic sub);
        logic [FP_W-1:0] r;
        r = b;
        r[FP_SIGN_BIT] = b[FP_SIGN_BIT] ^ sub;
        return r;
    endfunction

endpackage

// File: rtl/fp_nan_detect.sv
// Combinational NaN / signalling-NaN classifier for a single-precision word.
// Only compiled when FP_ADDSUB_NAN_CANON_EN is defined.
`ifdef FP_ADDSUB_NAN_CANON_EN
module fp_nan_detect
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] word,
    output logic            is_nan,
    output logic            is_snan
);

    logic exp_ones;
    logic man_nz;

    // A NaN has an all-ones exponent and non-zero mantissa; quiet bit is the mantissa MSB.
    always_comb begin
        exp_ones = &word[FP_EXP_MSB:FP_EXP_LSB];
        man_nz   = |word[FP_MAN_MSB:0];
        is_nan   = exp_ones & man_nz;
        is_snan  = exp_ones & man_nz & ~word[FP_MAN_MSB];
    end

endmodule
`endif

// File: rtl/fp_addsub_seq.sv
// Issue/capture stage in front of the combinational single-precision add/sub
// datapath: registers operands, holds them for SETTLE_CYCLES, captures the
// result and flags, and accumulates sticky fflags.
// Optional build macro: FP_ADDSUB_NAN_CANON_EN adds NaN canonicalisation,
// the NV flag and the rsp_invalid port.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FP_W-1:0]   req_a,
    input  logic [FP_W-1:0]   req_b,
    input  logic              req_sub,
    output logic [FP_W-1:0]   dp_a,
    output logic [FP_W-1:0]   dp_b,
    input  logic [FP_W-1:0]   dp_result,
    input  logic              dp_overflow,
    input  logic              dp_underflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FP_W-1:0]   rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_underflow,
`ifdef FP_ADDSUB_NAN_CANON_EN
    output logic              rsp_invalid,
`endif
    output logic [FLAG_N-1:0] fflags_sticky,
    input  logic              fflags_clr,
    output logic              busy
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               capture;
    logic [FP_W-1:0]    cap_result;
    logic [FLAG_N-1:0]  cap_flags;
    logic [FLAG_N-1:0]  rsp_flags;

`ifdef FP_ADDSUB_NAN_CANON_EN
    logic res_nan;
    logic res_snan;
    logic a_nan;
    logic a_snan;
    logic b_nan;
    logic b_snan;

    fp_nan_detect u_nan_res (.word(dp_result), .is_nan(res_nan), .is_snan(res_snan));
    fp_nan_detect u_nan_a   (.word(dp_a),      .is_nan(a_nan),   .is_snan(a_snan));
    fp_nan_detect u_nan_b   (.word(dp_b),      .is_nan(b_nan),   .is_snan(b_snan));

    // Canonicalise any NaN result; NV comes from signalling-NaN operands.
    always_comb begin
        cap_result         = res_nan ? CANON_NAN : dp_result;
        cap_flags          = '0;
        cap_flags[FLAG_OF] = dp_overflow;
        cap_flags[FLAG_UF] = dp_underflow;
        cap_flags[FLAG_NV] = a_snan | b_snan;
    end

    assign rsp_invalid = rsp_flags[FLAG_NV];
`else
    // Result passes through untouched; only OF/UF are tracked.
    always_comb begin
        cap_result         = dp_result;
        cap_flags          = '0;
        cap_flags[FLAG_OF] = dp_overflow;
        cap_flags[FLAG_UF] = dp_underflow;
    end
`endif

    assign rsp_overflow  = rsp_flags[FLAG_OF];
    assign rsp_underflow = rsp_flags[FLAG_UF];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    load      = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle down-counter; terminal count triggers the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt <= '0;
        else if (load)                       cnt <= CNT_W'(SETTLE_CYCLES - 1);
        else if (state == SETTLE && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Operand registers feeding the datapath; held after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a <= '0;
            dp_b <= '0;
        end else if (load) begin
            dp_a <= req_a;
            dp_b <= apply_sub(req_b, req_sub);
        end
    end

    // Response registers: loaded at capture, valid dropped on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= cap_result;
            rsp_flags  <= cap_flags;
        end else if (state == DONE && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Sticky flags; a coincident clear beats accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          fflags_sticky <= '0;
        else if (fflags_clr) fflags_sticky <= '0;
        else if (capture)    fflags_sticky <= fflags_sticky | cap_flags;
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq with a behavioural single-precision adder
// as the datapath and a scoreboard queue of expected responses.
// Define FP_ADDSUB_NAN_CANON_EN to also exercise NaN canonicalisation.
module tb_fp_addsub_seq;
    import fp_pkg::*;

    localparam int SETTLE = 2;

    typedef struct {
        logic [31:0] res;
        logic        of;
        logic        uf;
        logic        nv;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic              req_sub;
    logic [31:0]       dp_a;
    logic [31:0]       dp_b;
    logic [31:0]       dp_result;
    logic              dp_overflow;
    logic              dp_underflow;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_overflow;
    logic              rsp_underflow;
    logic [FLAG_N-1:0] fflags_sticky;
    logic              fflags_clr;
    logic              busy;
`ifdef FP_ADDSUB_NAN_CANON_EN
    logic              rsp_invalid;
`endif

    exp_t sb[$];
    int   passed;
    int   total;

    fp_addsub_seq #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_result(dp_result), .dp_overflow(dp_overflow), .dp_underflow(dp_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
`ifdef FP_ADDSUB_NAN_CANON_EN
        .rsp_invalid(rsp_invalid),
`endif
        .fflags_sticky(fflags_sticky), .fflags_clr(fflags_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder (denormals flushed, truncating): returns {of, uf, result}.
    function automatic logic [33:0] model_add(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        logic [49:0] xa, xb;
        logic [50:0] sum, norm;
        int          d, p, e;
        a = a_in; b = b_in;
        if (a[30:23] == 8'hFF && a[22:0] != 0) return {2'b00, a};
        if (b[30:23] == 8'hFF && b[22:0] != 0) return {2'b00, b};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return {2'b00, 32'h7FC00000};
            return {2'b00, (a[30:23] == 8'hFF) ? a : b};
        end
        if (a[30:0] < b[30:0]) begin a = b_in; b = a_in; end
        ea = a[30:23]; eb = b[30:23];
        if (ea == 0) return {2'b00, (a[31] & b[31]) ? 32'h80000000 : 32'h0};
        if (eb == 0) return {2'b00, a};
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        d  = int'(ea) - int'(eb);
        xa = {ma, 26'b0};
        xb = (d > 49) ? 50'b0 : ({mb, 26'b0} >> d);
        sum = (a[31] == b[31]) ? ({1'b0, xa} + {1'b0, xb}) : ({1'b0, xa} - {1'b0, xb});
        if (sum == 0) return 34'h0;
        p = 0;
        for (int i = 0; i < 51; i++) if (sum[i]) p = i;
        e = int'(ea) + p - 49;
        if (e >= 255) return {2'b10, a[31], 8'hFF, 23'h0};
        if (e <= 0)   return {2'b01, a[31], 31'h0};
        norm = sum << (50 - p);
        return {2'b00, a[31], e[7:0], norm[49:27]};
    endfunction

    always_comb {dp_overflow, dp_underflow, dp_result} = model_add(dp_a, dp_b);

    // Hold a request until accepted (bounded); queue its expected response.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] res, input logic of, input logic uf, input logic nv,
                         output logic ok);
        exp_t e;
        req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (ok) begin
            e.res = res; e.of = of; e.uf = uf; e.nv = nv;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for rsp_valid; report edges taken and any req_ready seen.
    task automatic wait_rsp(output logic ok, output int cycles, output logic rdy_seen);
        cycles = 0; rdy_seen = 1'b0;
        while (!rsp_valid && cycles < 50) begin
            if (req_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        ok = rsp_valid;
    endtask

    task automatic retire();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (dp_a !== 32'h0) $display("FAIL reset_dp_a got %h want 0", dp_a); else passed++;
        total++; if (dp_b !== 32'h0) $display("FAIL reset_dp_b got %h want 0", dp_b); else passed++;
        total++; if (rsp_result !== 32'h0) $display("FAIL reset_rsp_result got %h want 0", rsp_result); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        total++; if (fflags_sticky !== '0) $display("FAIL reset_fflags got %b want 0", fflags_sticky); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_sub_zero();
        logic ok, rdy; int cyc; exp_t e;
        issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, ok);
        total++; if (ok !== 1'b1) $display("FAIL sub_zero_accept got %b want 1", ok); else passed++;
        total++; if (dp_b !== 32'hBF800000) $display("FAIL sub_zero_dp_b got %h want bf800000", dp_b); else passed++;
        total++; if (dp_a !== 32'h3F800000) $display("FAIL sub_zero_dp_a got %h want 3f800000", dp_a); else passed++;
        wait_rsp(ok, cyc, rdy);
        total++; if (ok !== 1'b1) $display("FAIL sub_zero_timeout got %b want 1", ok); else passed++;
        total++; if (cyc != SETTLE) $display("FAIL sub_zero_latency got %0d want %0d", cyc, SETTLE); else passed++;
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            total++; if (rsp_result !== e.res) $display("FAIL sub_zero_result got %h want %h", rsp_result, e.res); else passed++;
            total++; if ({rsp_overflow, rsp_underflow} !== {e.of, e.uf}) $display("FAIL sub_zero_flags got %b%b want %b%b", rsp_overflow, rsp_underflow, e.of, e.uf); else passed++;
        end
        total++; if (fflags_sticky !== '0) $display("FAIL sub_zero_sticky got %b want 0", fflags_sticky); else passed++;
        retire();
        total++; if (rsp_valid !== 1'b0) $display("FAIL sub_zero_retire_valid got %b want 0", rsp_valid); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL sub_zero_retire_ready got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_sequence();
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        logic        ts [2];
        logic ok, rdy; int cyc; exp_t e;
        ta[0] = 32'h40400000; tb[0] = 32'h3F800000; ts[0] = 1'b1;
        ta[1] = 32'h3F800000; tb[1] = 32'h3F800000; ts[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            issue(ta[k], tb[k], ts[k], 32'h40000000, 1'b0, 1'b0, 1'b0, ok);
            total++; if (req_ready !== 1'b0) $display("FAIL seq%0d_ready_after_accept got %b want 0", k, req_ready); else passed++;
            wait_rsp(ok, cyc, rdy);
            total++; if (ok !== 1'b1) $display("FAIL seq%0d_timeout got %b want 1", k, ok); else passed++;
            total++; if (rdy !== 1'b0) $display("FAIL seq%0d_ready_in_settle got %b want 0", k, rdy); else passed++;
            total++; if (req_ready !== 1'b0) $display("FAIL seq%0d_ready_in_done got %b want 0", k, req_ready); else passed++;
            if (ok && sb.size() > 0) begin
                e = sb.pop_front();
                total++; if (rsp_result !== e.res) $display("FAIL seq%0d_result got %h want %h", k, rsp_result, e.res); else passed++;
            end
            retire();
            total++; if (req_ready !== 1'b1) $display("FAIL seq%0d_ready_idle got %b want 1", k, req_ready); else passed++;
        end
    endtask

    task automatic test_overflow();
        logic ok, rdy; int cyc; exp_t e;
        logic [FLAG_N-1:0] of_flag;
        of_flag = '0; of_flag[FLAG_OF] = 1'b1;
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, ok);
        wait_rsp(ok, cyc, rdy);
        total++; if (ok !== 1'b1) $display("FAIL ovf_timeout got %b want 1", ok); else passed++;
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            total++; if (rsp_result !== e.res) $display("FAIL ovf_result got %h want %h", rsp_result, e.res); else passed++;
            total++; if (rsp_overflow !== e.of) $display("FAIL ovf_flag got %b want %b", rsp_overflow, e.of); else passed++;
        end
        total++; if (fflags_sticky !== of_flag) $display("FAIL ovf_sticky got %b want %b", fflags_sticky, of_flag); else passed++;
        retire();
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, ok);
        wait_rsp(ok, cyc, rdy);
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            total++; if (rsp_overflow !== e.of) $display("FAIL ovf_next_flag got %b want %b", rsp_overflow, e.of); else passed++;
        end
        total++; if (fflags_sticky !== of_flag) $display("FAIL ovf_sticky_held got %b want %b", fflags_sticky, of_flag); else passed++;
        retire();
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        total++; if (fflags_sticky !== '0) $display("FAIL ovf_clr got %b want 0", fflags_sticky); else passed++;
        // Clear coinciding with the capture edge wins over accumulation.
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, ok);
        repeat (SETTLE - 1) begin @(posedge clk); #1; end
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        total++; if (rsp_valid !== 1'b1) $display("FAIL clr_cap_valid got %b want 1", rsp_valid); else passed++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++; if (rsp_overflow !== e.of) $display("FAIL clr_cap_rsp_of got %b want %b", rsp_overflow, e.of); else passed++;
        end
        total++; if (fflags_sticky !== '0) $display("FAIL clr_cap_sticky got %b want 0", fflags_sticky); else passed++;
        retire();
    endtask

    task automatic test_backpressure();
        logic ok, rdy; int cyc; exp_t e;
        logic stable;
        issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0, ok);
        wait_rsp(ok, cyc, rdy);
        total++; if (ok !== 1'b1) $display("FAIL bp_timeout got %b want 1", ok); else passed++;
        e.res = 32'h0; e.of = 1'b0; e.uf = 1'b0; e.nv = 1'b0;
        if (sb.size() > 0) e = sb.pop_front();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                req_a = 32'h41200000; req_b = 32'h3F800000; req_sub = 1'b0; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_result !== e.res) stable = 1'b0;
        end
        req_valid = 1'b0;
        total++; if (stable !== 1'b1) $display("FAIL bp_stable got %b want 1 (result %h want %h)", stable, rsp_result, e.res); else passed++;
        total++; if (dp_a !== 32'h40400000) $display("FAIL bp_no_accept got %h want 40400000", dp_a); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL bp_busy got %b want 1", busy); else passed++;
        retire();
        total++; if (busy !== 1'b0) $display("FAIL bp_idle_busy got %b want 0", busy); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL bp_idle_ready got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_async_reset();
        logic ok, rdy; int cyc; logic stale;
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, ok);
        wait_rsp(ok, cyc, rdy);
        if (sb.size() > 0) void'(sb.pop_front());
        retire();
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, ok);
        @(posedge clk); #2;
        total++; if (fflags_sticky === '0) $display("FAIL arst_pre_sticky got %b want nonzero", fflags_sticky); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", rsp_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else passed++;
        total++; if (fflags_sticky !== '0) $display("FAIL arst_sticky got %b want 0", fflags_sticky); else passed++;
        if (ok && sb.size() > 0) void'(sb.pop_back());
        #4;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) stale = 1'b1;
        end
        total++; if (stale !== 1'b0) $display("FAIL arst_stale_rsp got %b want 0", stale); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL arst_ready got %b want 1", req_ready); else passed++;
    endtask

`ifdef FP_ADDSUB_NAN_CANON_EN
    task automatic test_nan();
        logic ok, rdy; int cyc; exp_t e;
        issue(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, ok);
        wait_rsp(ok, cyc, rdy);
        total++; if (ok !== 1'b1) $display("FAIL nan_timeout got %b want 1", ok); else passed++;
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            total++; if (rsp_result !== e.res) $display("FAIL nan_result got %h want %h", rsp_result, e.res); else passed++;
            total++; if (rsp_invalid !== e.nv) $display("FAIL nan_invalid got %b want %b", rsp_invalid, e.nv); else passed++;
        end
        total++; if (fflags_sticky[FLAG_NV] !== 1'b1) $display("FAIL nan_sticky_nv got %b want 1", fflags_sticky[FLAG_NV]); else passed++;
        retire();
    endtask
`endif

    initial begin
        passed = 0; total = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0;
        rsp_ready = 1'b0; fflags_clr = 1'b0;
        test_reset();
        test_sub_zero();
        test_sequence();
        test_overflow();
        test_backpressure();
        test_async_reset();
`ifdef FP_ADDSUB_NAN_CANON_EN
        test_nan();
`endif
        total++; if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
